wddl_prechg_buf_32: RTL and testbench

WDDL_PRECHG_BUF_32 -- requirements
Module: wddl_prechg_buf_32

---
 rtl/wddl_prechg_buf_32.sv | 125 ++++++++++++
 tb/tb_wddl_prechg_buf_32.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/wddl_prechg_buf_32.sv
// Two-entry dual-rail WDDL buffer with a precharge/evaluate output stage.
// Define WDDL_RAIL_CHECK_EN to enable the sticky rail-complementarity error flag.
module wddl_prechg_buf_32 #(
  parameter int DEPTH_LOG2 = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] d_p_in,
  input  logic [31:0] d_n_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] d_p_out,
  output logic [31:0] d_n_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        pre_out,
  output logic        err_out
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {
    PRE  = 1'b0,
    EVAL = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [1:0]  count;
  logic [1:0]  count_next;
  logic        wr_ptr;
  logic        rd_ptr;
  logic        push;
  logic        pop;
  logic        load;
  logic [31:0] mem_p [DEPTH];
  logic [31:0] mem_n [DEPTH];

  // Next-state, handshake and occupancy decisions.
  always_comb begin
    push       = in_valid && in_ready;
    pop        = 1'b0;
    load       = 1'b0;
    state_next = state;
    count_next = count;
    case (state)
      PRE: begin
        if (count != 2'd0) begin
          state_next = EVAL;
          load       = 1'b1;
        end
      end
      EVAL: begin
        if (out_ready) begin
          state_next = PRE;
          pop        = 1'b1;
        end
      end
      default: state_next = PRE;
    endcase
    case ({push, pop})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase
  end

  // in_ready is registered from the next occupancy so out_ready never reaches it combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= PRE;
      count    <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      in_ready <= 1'b0;
    end else begin
      state    <= state_next;
      count    <= count_next;
      in_ready <= (count_next < 2'(DEPTH));
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_p[wr_ptr] <= d_p_in;
      mem_n[wr_ptr] <= d_n_in;
    end
  end

  // Output rails are loaded on entry to EVAL and return to all-zero precharge on pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_p_out   <= 32'd0;
      d_n_out   <= 32'd0;
      out_valid <= 1'b0;
      pre_out   <= 1'b1;
    end else if (load) begin
      d_p_out   <= mem_p[rd_ptr];
      d_n_out   <= mem_n[rd_ptr];
      out_valid <= 1'b1;
      pre_out   <= 1'b0;
    end else if (pop) begin
      d_p_out   <= 32'd0;
      d_n_out   <= 32'd0;
      out_valid <= 1'b0;
      pre_out   <= 1'b1;
    end
  end

`ifdef WDDL_RAIL_CHECK_EN
  // Any bit whose rails agree on an accepted word is a complementarity violation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_out <= 1'b0;
    end else if (push && ((~(d_p_in ^ d_n_in)) != 32'd0)) begin
      err_out <= 1'b1;
    end
  end
`else
  assign err_out = 1'b0;
`endif

endmodule

// File: tb/tb_wddl_prechg_buf_32.sv
// Scoreboard bench for wddl_prechg_buf_32: directed scenarios followed by random traffic.
module tb_wddl_prechg_buf_32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] d_p_in = 32'd0;
  logic [31:0] d_n_in = 32'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] d_p_out;
  logic [31:0] d_n_out;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        pre_out;
  logic        err_out;

`ifdef WDDL_RAIL_CHECK_EN
  localparam bit RAIL_CHK = 1'b1;
`else
  localparam bit RAIL_CHK = 1'b0;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  logic [63:0] sb_q[$];
  bit m_eval = 1'b0;
  bit m_rdy  = 1'b0;
  bit m_err  = 1'b0;
  bit m_acc  = 1'b0;

  wddl_prechg_buf_32 #(.DEPTH_LOG2(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .d_p_in    (d_p_in),
    .d_n_in    (d_n_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d_p_out   (d_p_out),
    .d_n_out   (d_n_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pre_out   (pre_out),
    .err_out   (err_out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a word queue whose head is shown once the buffer has held it for a cycle.
  always @(posedge clk) begin : model
    int sz;
    bit push_e;
    bit pop_e;
    if (rst_n) begin
      sz     = sb_q.size();
      push_e = in_valid && m_rdy && (sz < 2);
      pop_e  = m_eval && out_ready;
      m_acc  = push_e;
      if (m_eval) m_eval = !out_ready;
      else        m_eval = (sz > 0);
      if (pop_e) void'(sb_q.pop_front());
      if (push_e) begin
        sb_q.push_back({d_p_in, d_n_in});
        if (RAIL_CHK && ((~(d_p_in ^ d_n_in)) != 32'd0)) m_err = 1'b1;
      end
      m_rdy = 1'b1;
    end else begin
      m_acc = 1'b0;
    end
  end

  always @(negedge rst_n) begin
    sb_q.delete();
    m_eval = 1'b0;
    m_rdy  = 1'b0;
    m_err  = 1'b0;
    m_acc  = 1'b0;
  end

  always @(negedge clk) begin : monitor
    if (m_eval) begin
      checkOutput("out_valid", {63'd0, out_valid}, 64'd1);
      checkOutput("d_p_out", {32'd0, d_p_out}, {32'd0, sb_q[0][63:32]});
      checkOutput("d_n_out", {32'd0, d_n_out}, {32'd0, sb_q[0][31:0]});
      checkOutput("pre_out", {63'd0, pre_out}, 64'd0);
    end else begin
      checkOutput("out_valid", {63'd0, out_valid}, 64'd0);
      checkOutput("d_p_out_pre", {32'd0, d_p_out}, 64'd0);
      checkOutput("d_n_out_pre", {32'd0, d_n_out}, 64'd0);
      checkOutput("pre_out", {63'd0, pre_out}, 64'd1);
    end
    checkOutput("in_ready", {63'd0, in_ready}, {63'd0, (m_rdy && (sb_q.size() < 2))});
    checkOutput("err_out", {63'd0, err_out}, {63'd0, m_err});
  end

  task automatic applyStimulus(input logic [31:0] p, input logic [31:0] n);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    d_p_in   = p;
    d_n_in   = n;
    for (int i = 0; i < 50 && !done; i++) begin
      @(posedge clk);
      #1;
      done = m_acc;
    end
    in_valid = 1'b0;
    checkOutput("send_accept", {63'd0, done}, 64'd1);
  endtask

  initial begin : stim
    logic [31:0] p;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // Single word into an empty buffer with the consumer ready.
    out_ready = 1'b1;
    applyStimulus(32'hA5A5_0F0F, 32'h5A5A_F0F0);
    repeat (4) @(posedge clk);
    #1;

    // Consumer stalled: two words fill the buffer, the third waits upstream.
    out_ready = 1'b0;
    applyStimulus(32'h1111_2222, ~32'h1111_2222);
    applyStimulus(32'h3333_4444, ~32'h3333_4444);
    in_valid = 1'b1;
    d_p_in   = 32'h5555_6666;
    d_n_in   = ~32'h5555_6666;
    repeat (4) @(posedge clk);
    #1;
    out_ready = 1'b1;
    applyStimulus(32'h5555_6666, ~32'h5555_6666);
    repeat (6) @(posedge clk);
    #1;

    // Eight words streamed with the consumer always ready.
    for (int i = 0; i < 8; i++) begin
      p = $urandom;
      applyStimulus(p, ~p);
    end
    repeat (6) @(posedge clk);
    #1;

    // Rails agreeing on bit 0.
    applyStimulus(32'h0000_0001, 32'hFFFF_FFFF);
    repeat (4) @(posedge clk);
    #1;

    // Reset in the middle of EVAL with both entries occupied.
    out_ready = 1'b0;
    applyStimulus(32'hDEAD_BEEF, ~32'hDEAD_BEEF);
    applyStimulus(32'hCAFE_F00D, ~32'hCAFE_F00D);
    checkOutput("pre_rst_valid", {63'd0, out_valid}, 64'd1);
    checkOutput("pre_rst_ready", {63'd0, in_ready}, 64'd0);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("rst_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("rst_d_p", {32'd0, d_p_out}, 64'd0);
    checkOutput("rst_d_n", {32'd0, d_n_out}, 64'd0);
    checkOutput("rst_pre", {63'd0, pre_out}, 64'd1);
    checkOutput("rst_ready", {63'd0, in_ready}, 64'd0);
    checkOutput("rst_err", {63'd0, err_out}, 64'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_rst_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("post_rst_valid", {63'd0, out_valid}, 64'd0);

    // Random traffic with occasional non-complementary words.
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      p         = $urandom;
      d_p_in    = p;
      d_n_in    = ($urandom_range(0, 15) == 0) ? (~p ^ (32'd1 << $urandom_range(0, 31))) : ~p;
      @(posedge clk);
      #1;
    end

    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("drain_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("drain_ready", {63'd0, in_ready}, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
